// File: rtl/timer_regfile_core.sv
// timer_regfile_core: bus-slave register file (CONTROL/LOAD/STATUS) driving a
// 32-bit down-counter with one-shot or auto-reload expiry.
// Optional feature macro: SOC_TIMER_IRQ_EN adds the irq output and CONTROL.IRQ_EN (bit3).
module timer_regfile_core #(
    parameter int P_ADDR_WIDTH = 8,
    parameter int P_DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic                    write_en,
    input  logic [P_ADDR_WIDTH-1:0] addr,
    input  logic [P_DATA_WIDTH-1:0] wdata,
    output logic                    gnt,
    output logic [P_DATA_WIDTH-1:0] rdata,
`ifdef SOC_TIMER_IRQ_EN
    output logic                    irq,
`endif
    output logic                    expired
);

    localparam logic [P_ADDR_WIDTH-1:0] L_ADDR_CONTROL = P_ADDR_WIDTH'('h00);
    localparam logic [P_ADDR_WIDTH-1:0] L_ADDR_LOAD    = P_ADDR_WIDTH'('h04);
    localparam logic [P_ADDR_WIDTH-1:0] L_ADDR_STATUS  = P_ADDR_WIDTH'('h08);

    localparam int L_BIT_START     = 0;
    localparam int L_BIT_RELOAD_EN = 1;
    localparam int L_BIT_CLR_STAT  = 2;
    localparam int L_BIT_IRQ_EN    = 3;
    localparam int L_BIT_EXPIRED   = 0;

    logic                    r_gnt;
    logic [P_DATA_WIDTH-1:0] r_rdata;
    logic                    r_start;
    logic                    r_reload_en;
    logic                    r_irq_en;
    logic [P_DATA_WIDTH-1:0] r_load;
    logic [P_DATA_WIDTH-1:0] r_count;
    logic                    r_expired;

    logic                    w_accept;
    logic                    w_wr;
    logic                    w_rd;
    logic                    w_ctrl_wr;
    logic                    w_load_wr;
    logic                    w_expire;
    logic                    w_start_rise;
    logic [P_DATA_WIDTH-1:0] w_rdata;

    // A transfer is taken on any edge where the master requests and no grant is outstanding.
    assign w_accept     = req & ~r_gnt;
    assign w_wr         = w_accept & write_en;
    assign w_rd         = w_accept & ~write_en;
    assign w_ctrl_wr    = w_wr & (addr == L_ADDR_CONTROL);
    assign w_load_wr    = w_wr & (addr == L_ADDR_LOAD);
    assign w_expire     = r_start & (r_count == '0);
    assign w_start_rise = w_ctrl_wr & wdata[L_BIT_START] & ~r_start;

    // Read-data mux; unmapped addresses and write-only/reserved bits return 0.
    always_comb begin
        w_rdata = '0;
        case (addr)
            L_ADDR_CONTROL: begin
                w_rdata[L_BIT_START]     = r_start;
                w_rdata[L_BIT_RELOAD_EN] = r_reload_en;
                w_rdata[L_BIT_IRQ_EN]    = r_irq_en;
            end
            L_ADDR_LOAD:   w_rdata = r_load;
            L_ADDR_STATUS: w_rdata[L_BIT_EXPIRED] = r_expired;
            default:       w_rdata = '0;
        endcase
    end

    // Bus handshake: one-cycle grant pulse, read data captured at the accept edge and held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_gnt <= w_accept;
            if (w_rd) begin
                r_rdata <= w_rdata;
            end
        end
    end

    // CONTROL and LOAD registers; a software CONTROL write overrides the hardware START clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start     <= 1'b0;
            r_reload_en <= 1'b0;
            r_irq_en    <= 1'b0;
            r_load      <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_start     <= wdata[L_BIT_START];
                r_reload_en <= wdata[L_BIT_RELOAD_EN];
`ifdef SOC_TIMER_IRQ_EN
                r_irq_en    <= wdata[L_BIT_IRQ_EN];
`else
                r_irq_en    <= 1'b0;
`endif
            end else if (w_expire && !r_reload_en) begin
                r_start <= 1'b0;
            end
            if (w_load_wr) begin
                r_load <= wdata;
            end
        end
    end

    // Down-counter: load on START rising, decrement while running, reload from the pre-edge LOAD on expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_start_rise) begin
            r_count <= r_load;
        end else if (r_start) begin
            if (r_count != '0) begin
                r_count <= r_count - 1'b1;
            end else if (r_reload_en) begin
                r_count <= r_load;
            end
        end
    end

    // Sticky EXPIRED flag; a coincident expiry beats CLR_STATUS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_expired <= 1'b0;
        end else if (w_expire) begin
            r_expired <= 1'b1;
        end else if (w_ctrl_wr && wdata[L_BIT_CLR_STAT]) begin
            r_expired <= 1'b0;
        end
    end

`ifdef SOC_TIMER_IRQ_EN
    logic r_irq;

    // Registered interrupt: lags EXPIRED (set and clear) by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_expired & r_irq_en;
        end
    end

    assign irq = r_irq;
`endif

    assign gnt     = r_gnt;
    assign rdata   = r_rdata;
    assign expired = r_expired;

endmodule

// File: tb/tb_timer_regfile_core.sv
// tb_timer_regfile_core: scoreboard bench for timer_regfile_core.
// Each transfer pushes its expected outcome; a grant monitor pops and compares.
module tb_timer_regfile_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        write_en = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        gnt;
    logic [31:0] rdata;
    logic        expired;
`ifdef SOC_TIMER_IRQ_EN
    logic        irq;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        is_read;
        logic [31:0] exp;
        string       tag;
    } sb_t;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    timer_regfile_core #(.P_ADDR_WIDTH(8), .P_DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .write_en (write_en),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .rdata    (rdata),
`ifdef SOC_TIMER_IRQ_EN
        .irq      (irq),
`endif
        .expired  (expired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Grant monitor: every gnt must match a queued transfer; reads compare rdata.
    logic prev_gnt = 1'b0;
    always @(posedge clk) begin
        #1;
        if (gnt) begin
            chk("gnt_single_cycle", {31'd0, prev_gnt}, 32'd0);
            if (sb_q.size() == 0) begin
                chk("spurious_gnt", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                if (e.is_read) chk(e.tag, rdata, e.exp);
            end
        end
        prev_gnt = gnt;
    end

    task automatic xfer(input logic we, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string tag);
        sb_t e;
        logic g0;
        int n;
        @(negedge clk);
        g0 = gnt;
        req = 1'b1; write_en = we; addr = a; wdata = d;
        e.is_read = ~we; e.exp = exp; e.tag = tag;
        sb_q.push_back(e);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!gnt && n < 10);
        if (!gnt) chk({tag, "_gnt_timeout"}, 32'd0, 32'd1);
        else chk({tag, "_gnt_latency"}, n, g0 ? 32'd2 : 32'd1);
        req = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        xfer(1'b1, a, d, 32'd0, "write");
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
        xfer(1'b0, a, 32'd0, exp, tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset();
        chk("rst_gnt", {31'd0, gnt}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_expired", {31'd0, expired}, 32'd0);
        rd(8'h00, 32'd0, "rst_control");
        rd(8'h04, 32'd0, "rst_load");
        rd(8'h08, 32'd0, "rst_status");

        // One-shot: LOAD=5 expires exactly 6 cycles after the START edge
        wr(8'h04, 32'd5);
        wr(8'h00, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("oneshot_exp_c%0d", k), {31'd0, expired}, (k == 6) ? 32'd1 : 32'd0);
        end
        rd(8'h00, 32'h0, "oneshot_ctrl_cleared");
        rd(8'h08, 32'h1, "oneshot_status");
        repeat (5) @(posedge clk);
        rd(8'h08, 32'h1, "oneshot_status_sticky");

        // Auto-reload: LOAD=3 gives an expiry every 4 cycles
        do_reset();
        wr(8'h04, 32'd3);
        wr(8'h00, 32'h3);                      // START edge Ps
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("reload_exp_c%0d", k), {31'd0, expired}, (k == 4) ? 32'd1 : 32'd0);
        end
        wr(8'h00, 32'h7);                      // clear at Ps+5
        rd(8'h08, 32'h0, "reload_status_cleared"); // accepted Ps+7
        @(posedge clk); #1;                    // Ps+8: next expiry
        chk("reload_reexpire", {31'd0, expired}, 32'd1);

        // CLR_STATUS landing on the expiry edge Ps+12: set wins
        repeat (3) @(posedge clk);             // to Ps+11
        wr(8'h00, 32'h7);                      // accepted Ps+12
        chk("setwins_expired", {31'd0, expired}, 32'd1);
        rd(8'h08, 32'h1, "setwins_status");
        rd(8'h00, 32'h3, "reload_ctrl_running");

        // Unmapped addresses
        do_reset();
        wr(8'h04, 32'h0000_1234);
        rd(8'h10, 32'd0, "unmapped_read");
        wr(8'hFC, 32'hDEAD_BEEF);
        rd(8'h04, 32'h0000_1234, "unmapped_load_intact");
        rd(8'h00, 32'h0, "unmapped_ctrl_intact");
        rd(8'h08, 32'h0, "unmapped_status_intact");

        // Asynchronous reset mid-count and mid-request
        wr(8'h04, 32'hFFFF_FFFF);
        wr(8'h00, 32'h1);
        rd(8'h04, 32'hFFFF_FFFF, "pre_abort_load");
        @(negedge clk);
        req = 1'b1; write_en = 1'b0; addr = 8'h04;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_gnt_now", {31'd0, gnt}, 32'd0);
        chk("abort_rdata_now", rdata, 32'd0);
        chk("abort_expired_now", {31'd0, expired}, 32'd0);
`ifdef SOC_TIMER_IRQ_EN
        chk("abort_irq_now", {31'd0, irq}, 32'd0);
`endif
        @(posedge clk); #2;
        chk("abort_no_gnt", {31'd0, gnt}, 32'd0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd(8'h00, 32'h0, "abort_control");
        rd(8'h04, 32'h0, "abort_load");
        rd(8'h08, 32'h0, "abort_status");

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_regfile_core.md
Name: timer_regfile_core

Overview:
- Bus-slave register file plus 32-bit down-counter implementing the SoC timer's programmer-visible map: CONTROL 0x00, LOAD 0x04, STATUS 0x08.
- Sits directly downstream of the design parameter package and consumes its address constants and bit positions.
- Sits upstream of the interrupt/status consumers. It is the block the verification environment drives through its bus agent.

Parameters:
- P_ADDR_WIDTH, 8, bus address width (from design params package).
- P_DATA_WIDTH, 32, data, LOAD and counter width (from design params package).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- req  in  1  bus request; held high by master until gnt
- write_en  in  1  1 = write, 0 = read; valid while req
- addr  in  P_ADDR_WIDTH  register byte address; valid while req
- wdata  in  P_DATA_WIDTH  write data; valid while req
- gnt  out  1  one-cycle completion pulse
- rdata  out  P_DATA_WIDTH  read data, valid in gnt cycle
- expired  out  1  mirror of STATUS.EXPIRED

Interface (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset:
  - gnt=0, rdata=0, expired=0.
  - CONTROL=0, LOAD=0, STATUS=0, count=0.
  - Asserting rst_n low mid-transfer or mid-count aborts everything immediately. No gnt is issued for the aborted request.
- Bus handshake:
  - A transfer is accepted at the rising edge where req=1 and gnt=0.
  - At that edge gnt<=1. For a write, the register update lands at the same edge. For a read, rdata is registered at the same edge.
  - gnt is high for exactly one cycle. Minimum 2 cycles per transfer.
  - If req is still high in the cycle after gnt, it is a new transfer.
  - rdata holds its last value outside gnt cycles.
- Register map:
  - CONTROL: bit0 START (RW), bit1 RELOAD_EN (RW), bit2 CLR_STATUS (write-1 pulse, reads 0). Other bits read 0.
  - LOAD: 32-bit RW. Writing it does not touch count.
  - STATUS: bit0 EXPIRED, sticky, read-only. Writes to STATUS are ignored.
  - Unmapped address: write ignored, read returns 0, gnt still issued.
- Counter:
  - A START 0->1 write copies LOAD into count at that edge.
  - A write with START=1 while already running leaves count unchanged.
  - While START=1 and count!=0: count decrements by 1 each cycle.
  - While START=1 and count==0 (expiry event): EXPIRED<=1. Then:
    - RELOAD_EN=1: count<=LOAD.
    - RELOAD_EN=0: hardware clears START; count stays 0.
  - Resulting period with reload: LOAD+1 cycles per expiry. LOAD=0 with reload gives an expiry every cycle.
  - START=0 (software write) freezes count at its current value. A later START 0->1 reloads from LOAD; there is no resume.
- Simultaneous events:
  - Expiry and CLR_STATUS in the same cycle: set wins, EXPIRED=1.
  - Expiry and a CONTROL write clearing START in the same cycle: the write wins, START=0. EXPIRED is still set.
  - LOAD write in the same cycle as a reload: the reload uses the old LOAD. The new value applies from the next reload.
  - Read of STATUS in the expiry cycle returns the pre-edge value.
- No arithmetic wraps: count never decrements below 0.

Optional Feature:
- Macro: SOC_TIMER_IRQ_EN.
- Defined:
  - Adds output irq (1 bit, reset 0) and CONTROL bit3 IRQ_EN (RW, reset 0).
  - irq is registered: irq = EXPIRED & IRQ_EN.
  - irq asserts one cycle after EXPIRED sets and drops one cycle after CLR_STATUS.
- Undefined: no irq port; CONTROL bit3 reads 0 and writes are ignored.

Test Plan:
- Reset, then read 0x00, 0x04 and 0x08 -> each returns 0, gnt one cycle after req, expired=0.
- Write LOAD=5, then CONTROL=0x1 (one-shot) -> EXPIRED=1 exactly 6 cycles after the START edge; CONTROL reads 0x0 afterwards; count holds 0.
- LOAD=3, CONTROL=0x3 (reload) -> expiry events every 4 cycles. Write CONTROL=0x7 -> STATUS reads 0; the next expiry sets it again.
- CLR_STATUS write timed onto an expiry cycle -> STATUS reads 1 (set wins).
- Read 0x10 and write 0xFC with 0xDEADBEEF -> read returns 0, gnt issued, no register changes.
- rst_n pulsed low while running with LOAD=0xFFFF_FFFF -> all registers and outputs 0 immediately, no gnt; under SOC_TIMER_IRQ_EN, irq=0.
